// File: rtl/cache_test_gen_pkg.sv
// Shared constants and LFSR step helper for the cache traffic generator.
// Request encodings are shared with the CPU-side request port.
package cache_test_gen_pkg;

   localparam logic        REQ_READ  = 1'b0;
   localparam logic        REQ_WRITE = 1'b1;
   localparam int          BUS_64    = 64;
   // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef logic [BUS_64-1:0] addr_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] r;
      r = {1'b0, s[31:1]};
      if (s[0]) begin
         r = r ^ LFSR_TAPS;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_test_lfsr.sv
// Combinational LFSR unroll: word j of the pattern is the state after j+1 steps;
// next_state is the state after WORDS steps.
module cache_test_lfsr
   import cache_test_gen_pkg::*;
#(
   parameter int WORDS = 16
) (
   input  logic [31:0]         state,
   output logic [WORDS*32-1:0] pattern,
   output logic [31:0]         next_state
);

   logic [31:0] walk_s;

   // Walk the LFSR WORDS steps, capturing each intermediate state as a data word
   always_comb begin
      walk_s  = state;
      pattern = '0;
      for (int j = 0; j < WORDS; j++) begin
         walk_s              = lfsr_step(walk_s);
         pattern[32*j +: 32] = walk_s;
      end
      next_state = walk_s;
   end

endmodule

// File: rtl/cache_test_gen.sv
// Cache traffic generator/checker: writes NUM_LINES LFSR-patterned lines, reads
// them back, compares against regenerated data and reports pass/fail.
module cache_test_gen
   import cache_test_gen_pkg::*;
#(
   parameter int          DATA_W     = 512,
   parameter int          NUM_LINES  = 16,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int          GAP_CYCLES = 1000,
   parameter int          MODE       = 0,
   parameter logic [31:0] SEED       = 32'hACE1_2021
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_ack,
   input  logic [DATA_W-1:0] i_rdata,
   output logic              o_req,
   output logic [BUS_64-1:0] o_addr,
   output logic              o_op,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [15:0]       o_err_cnt,
   output logic [BUS_64-1:0] o_fail_addr
);

   localparam int          WORDS      = DATA_W / 32;
   localparam logic [63:0] LINE_BYTES = 64'(DATA_W / 8);
   // GAP always holds at least one cycle so o_req is low after every handshake
   localparam logic [31:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
   localparam logic [15:0] LAST_LINE  = 16'(NUM_LINES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_REQ  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [31:0]       gap_cnt_r;
   logic [15:0]       line_r;
   logic              op_r;
   logic [31:0]       lfsr_r;
   logic [DATA_W-1:0] exp_r;
   logic [DATA_W-1:0] pat_s;
   logic [31:0]       lfsr_next_s;
   logic [DATA_W-1:0] expected_s;
   logic              hs_s;
   logic              start_ok_s;
   logic              last_line_s;
   logic              mismatch_s;
   logic [15:0]       err_next_s;

   cache_test_lfsr #(.WORDS(WORDS)) u_lfsr (
      .state      (lfsr_r),
      .pattern    (pat_s),
      .next_state (lfsr_next_s)
   );

   // Handshake, start qualification and readback comparison
   always_comb begin
      hs_s        = o_req & i_ack;
      start_ok_s  = i_start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
      last_line_s = (line_r == LAST_LINE);
      if (MODE == 0) begin
         expected_s = o_wdata;
      end else begin
         expected_s = exp_r;
      end
      mismatch_s = hs_s & (op_r == REQ_READ) & (i_rdata != expected_s);
      if (mismatch_s && (o_err_cnt != 16'hFFFF)) begin
         err_next_s = o_err_cnt + 16'd1;
      end else begin
         err_next_s = o_err_cnt;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) state_s = ST_GAP;
            else            state_s = ST_IDLE;
         end
         ST_GAP: begin
            if (gap_cnt_r == 32'd0) state_s = ST_REQ;
            else                    state_s = ST_GAP;
         end
         ST_REQ: begin
            if (hs_s && (op_r == REQ_READ) && last_line_s) state_s = ST_DONE;
            else if (hs_s)                                 state_s = ST_GAP;
            else                                           state_s = ST_REQ;
         end
         ST_DONE: begin
            if (start_ok_s) state_s = ST_GAP;
            else            state_s = ST_DONE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gap_cnt_r   <= 32'd0;
         line_r      <= 16'd0;
         op_r        <= REQ_WRITE;
         lfsr_r      <= SEED;
         exp_r       <= '0;
         o_req       <= 1'b0;
         o_addr      <= 64'd0;
         o_op        <= 1'b0;
         o_wdata     <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_err_cnt   <= 16'd0;
         o_fail_addr <= 64'd0;
      end else begin
         state_r <= state_s;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_ok_s) begin
                  o_busy      <= 1'b1;
                  o_done      <= 1'b0;
                  o_pass      <= 1'b0;
                  o_err_cnt   <= 16'd0;
                  o_fail_addr <= 64'd0;
                  line_r      <= 16'd0;
                  lfsr_r      <= SEED;
                  op_r        <= REQ_WRITE;
                  gap_cnt_r   <= GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == 32'd0) begin
                  o_req  <= 1'b1;
                  o_addr <= BASE_ADDR + ({48'd0, line_r} * LINE_BYTES);
                  o_op   <= op_r;
                  // Interleaved reads compare against o_wdata, so only writes
                  // and burst-mode reads consume LFSR steps.
                  if (op_r == REQ_WRITE) begin
                     o_wdata <= pat_s;
                     lfsr_r  <= lfsr_next_s;
                  end else if (MODE != 0) begin
                     exp_r  <= pat_s;
                     lfsr_r <= lfsr_next_s;
                  end
               end else begin
                  gap_cnt_r <= gap_cnt_r - 32'd1;
               end
            end
            ST_REQ: begin
               if (hs_s) begin
                  o_req     <= 1'b0;
                  gap_cnt_r <= GAP_LOAD;
                  o_err_cnt <= err_next_s;
                  if (mismatch_s && (o_err_cnt == 16'd0)) o_fail_addr <= o_addr;
                  if (op_r == REQ_READ) begin
                     if (last_line_s) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_pass <= (err_next_s == 16'd0);
                     end else begin
                        line_r <= line_r + 16'd1;
                        if (MODE == 0) op_r <= REQ_WRITE;
                     end
                  end else if (MODE == 0) begin
                     op_r <= REQ_READ;
                  end else if (last_line_s) begin
                     line_r <= 16'd0;
                     op_r   <= REQ_READ;
                     lfsr_r <= SEED;
                  end else begin
                     line_r <= line_r + 16'd1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_test_gen.sv
// Bench for cache_test_gen: interleaved and burst instances driven by a
// next-cycle-ack memory model, with a scoreboard of expected requests.
module tb_cache_test_gen;

   localparam int          DW   = 512;
   localparam logic [31:0] SEED = 32'hACE1_2021;
   localparam logic [63:0] BASE = 64'h8000_0000;

   typedef struct {
      logic        op;
      logic [63:0] addr;
      logic [DW-1:0] data;
   } item_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic a_start, a_ack, a_req, a_op, a_busy, a_done, a_pass;
   logic [DW-1:0] a_rdata, a_wdata;
   logic [63:0] a_addr, a_fail;
   logic [15:0] a_err;
   logic b_start, b_ack, b_req, b_op, b_busy, b_done, b_pass;
   logic [DW-1:0] b_rdata, b_wdata;
   logic [63:0] b_addr, b_fail;
   logic [15:0] b_err;

   cache_test_gen #(.DATA_W(DW), .NUM_LINES(2), .BASE_ADDR(BASE), .GAP_CYCLES(0),
                    .MODE(0), .SEED(SEED)) ua (
      .clk(clk), .rst(rst), .i_start(a_start), .i_ack(a_ack), .i_rdata(a_rdata),
      .o_req(a_req), .o_addr(a_addr), .o_op(a_op), .o_wdata(a_wdata), .o_busy(a_busy),
      .o_done(a_done), .o_pass(a_pass), .o_err_cnt(a_err), .o_fail_addr(a_fail));

   cache_test_gen #(.DATA_W(DW), .NUM_LINES(4), .BASE_ADDR(BASE), .GAP_CYCLES(3),
                    .MODE(1), .SEED(SEED)) ub (
      .clk(clk), .rst(rst), .i_start(b_start), .i_ack(b_ack), .i_rdata(b_rdata),
      .o_req(b_req), .o_addr(b_addr), .o_op(b_op), .o_wdata(b_wdata), .o_busy(b_busy),
      .o_done(b_done), .o_pass(b_pass), .o_err_cnt(b_err), .o_fail_addr(b_fail));

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int a_age = 0, b_age = 0, rd_b = 0;
   logic stray_a = 1'b0, flip_b = 1'b0, a_req_prev = 1'b0, b_req_prev = 1'b0;
   item_t qa[$], qb[$];
   int rise_a[$], hs_a[$], rise_b[$], hs_b[$];
   logic [DW-1:0] mem_a [logic [63:0]];
   logic [DW-1:0] mem_b [logic [63:0]];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic gen_line(inout logic [31:0] s, output logic [DW-1:0] d);
      for (int j = 0; j < DW / 32; j++) begin
         s = model_step(s);
         d[32*j +: 32] = s;
      end
   endtask

   task automatic push_a();
      logic [31:0] s = SEED;
      logic [DW-1:0] d;
      for (int n = 0; n < 2; n++) begin
         gen_line(s, d);
         qa.push_back('{1'b1, BASE + 64'(n * 64), d});
         qa.push_back('{1'b0, BASE + 64'(n * 64), d});
      end
   endtask

   task automatic push_b();
      logic [31:0] s = SEED;
      logic [DW-1:0] d [4];
      for (int n = 0; n < 4; n++) begin
         gen_line(s, d[n]);
         qb.push_back('{1'b1, BASE + 64'(n * 64), d[n]});
      end
      for (int n = 0; n < 4; n++) qb.push_back('{1'b0, BASE + 64'(n * 64), d[n]});
   endtask

   // One cycle: record edges, run both memory models and pop the scoreboard on acks
   task automatic step();
      item_t it;
      @(negedge clk);
      cyc++;
      if (a_req && !a_req_prev) rise_a.push_back(cyc);
      if (b_req && !b_req_prev) rise_b.push_back(cyc);
      a_req_prev = a_req;
      b_req_prev = b_req;
      a_ack = stray_a & ~a_req;
      b_ack = 1'b0;
      if (a_req && a_age == 1) begin
         a_ack = 1'b1;
         hs_a.push_back(cyc);
         chk("a_queue_nonempty", DW'(qa.size() != 0), DW'(1));
         if (qa.size() != 0) begin
            it = qa.pop_front();
            chk("a_op", DW'(a_op), DW'(it.op));
            chk("a_addr", DW'(a_addr), DW'(it.addr));
            if (it.op) begin
               chk("a_wdata", a_wdata, it.data);
               mem_a[a_addr] = a_wdata;
            end else begin
               a_rdata = mem_a.exists(a_addr) ? mem_a[a_addr] : '0;
            end
         end
      end
      if (b_req && b_age == 1) begin
         b_ack = 1'b1;
         hs_b.push_back(cyc);
         chk("b_queue_nonempty", DW'(qb.size() != 0), DW'(1));
         if (qb.size() != 0) begin
            it = qb.pop_front();
            chk("b_op", DW'(b_op), DW'(it.op));
            chk("b_addr", DW'(b_addr), DW'(it.addr));
            if (it.op) begin
               chk("b_wdata", b_wdata, it.data);
               mem_b[b_addr] = b_wdata;
            end else begin
               b_rdata = mem_b.exists(b_addr) ? mem_b[b_addr] : '0;
               if (flip_b && (rd_b == 1 || rd_b == 3)) b_rdata[0] = ~b_rdata[0];
               rd_b++;
            end
         end
      end
      a_age = a_req ? a_age + 1 : 0;
      b_age = b_req ? b_age + 1 : 0;
   endtask

   task automatic wait_done(input bit which, input int limit);
      int k = 0;
      while (!(which ? b_done : a_done) && k < limit) begin
         step();
         k++;
      end
      chk(which ? "b_done_in_time" : "a_done_in_time", DW'(which ? b_done : a_done), DW'(1));
   endtask

   initial begin
      int s_cyc;
      rst = 1'b1;
      a_start = 1'b0; b_start = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
      a_rdata = '0; b_rdata = '0;
      repeat (3) step();
      chk("a_reset_ctl", DW'({a_req, a_op, a_busy, a_done, a_pass, a_err, a_fail, a_addr}), '0);
      chk("b_reset_ctl", DW'({b_req, b_op, b_busy, b_done, b_pass, b_err, b_fail, b_addr}), '0);
      chk("b_reset_wdata", b_wdata, '0);
      rst = 1'b0;

      // Stray acks in IDLE must not start anything
      stray_a = 1'b1;
      repeat (3) step();
      stray_a = 1'b0;
      chk("a_idle_after_stray", DW'({a_req, a_busy, a_done, a_err}), '0);

      // Interleaved run with stray acks in GAP and a second start mid-run
      push_a();
      a_start = 1'b1;
      s_cyc = cyc;
      step();
      a_start = 1'b0;
      chk("a_busy_after_start", DW'(a_busy), DW'(1));
      stray_a = 1'b1;
      repeat (4) step();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (3) step();
      stray_a = 1'b0;
      wait_done(1'b0, 200);
      chk("a_first_rise", DW'(rise_a[0]), DW'(s_cyc + 2));
      chk("a_one_low_cycle", DW'(rise_a[1]), DW'(hs_a[0] + 2));
      chk("a_status", DW'({a_busy, a_done, a_pass, a_err, a_fail}), DW'({1'b0, 1'b1, 1'b1, 16'd0, 64'd0}));
      chk("a_queue_drained", DW'(qa.size()), '0);

      // Burst run with GAP=3 timing checks
      rise_b.delete(); hs_b.delete();
      push_b();
      b_start = 1'b1;
      s_cyc = cyc;
      step();
      b_start = 1'b0;
      wait_done(1'b1, 400);
      chk("b_first_rise", DW'(rise_b[0]), DW'(s_cyc + 4));
      chk("b_gap_after_hs", DW'(rise_b[1]), DW'(hs_b[0] + 4));
      chk("b_status", DW'({b_busy, b_done, b_pass, b_err, b_fail}), DW'({1'b0, 1'b1, 1'b1, 16'd0, 64'd0}));
      chk("b_queue_drained", DW'(qb.size()), '0);

      // Burst run with bit 0 flipped on reads 1 and 3
      flip_b = 1'b1; rd_b = 0;
      push_b();
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      chk("b_done_cleared_on_start", DW'({b_done, b_busy}), DW'(2'b01));
      wait_done(1'b1, 400);
      flip_b = 1'b0;
      chk("b_err_cnt", DW'(b_err), DW'(16'd2));
      chk("b_fail_addr", DW'(b_fail), DW'(64'h8000_0040));
      chk("b_err_flags", DW'({b_busy, b_done, b_pass}), DW'(3'b010));

      // Reset while o_req is high, then a fresh run from SEED
      push_b();
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      begin
         int k = 0;
         while (!b_req && k < 100) begin
            step();
            k++;
         end
      end
      chk("b_req_before_reset", DW'(b_req), DW'(1));
      rst = 1'b1;
      step();
      chk("b_mid_reset_ctl", DW'({b_req, b_op, b_busy, b_done, b_pass, b_err, b_fail, b_addr}), '0);
      chk("b_mid_reset_wdata", b_wdata, '0);
      rst = 1'b0;
      qb.delete();
      b_age = 0; rd_b = 0;
      push_b();
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      wait_done(1'b1, 400);
      chk("b_rerun_status", DW'({b_busy, b_done, b_pass, b_err, b_fail}), DW'({1'b0, 1'b1, 1'b1, 16'd0, 64'd0}));
      chk("b_rerun_queue_drained", DW'(qb.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
